// File: rtl/read_kick_pkg.sv
// Shared types and constants for the DDR ring read-kick scheduler.
package read_kick_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        KICK,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/ring_avail_calc.sv
// Combinational ring occupancy and next-chunk size; a chunk is capped by
// the data present, MAX_CHUNK and the distance to the physical ring end.
module ring_avail_calc #(
    parameter int unsigned RING_WORDS = 65536,
    parameter int unsigned MAX_CHUNK  = 1024,
    parameter int unsigned PW         = $clog2(RING_WORDS) + 1
) (
    input  logic [PW-1:0] wr_ptr,
    input  logic [PW-1:0] rd_ptr,
    output logic [PW-1:0] avail,
    output logic [PW-1:0] chunk
);

    logic [PW-1:0] to_end;
    logic [PW-1:0] capped;

    always_comb begin
        // Wrap bit makes the difference unambiguous: 0 is empty, RING_WORDS is full.
        avail  = wr_ptr - rd_ptr;
        to_end = PW'(RING_WORDS) - {1'b0, rd_ptr[PW-2:0]};
        capped = (avail > PW'(MAX_CHUNK)) ? PW'(MAX_CHUNK) : avail;
        chunk  = (capped > to_end) ? to_end : capped;
    end

endmodule

// File: rtl/read_kick_sched.sv
// Schedules AXI read kicks out of a DDR ring and advances the consumer pointer
// once each read finishes. Optional WAIT_BUSY watchdog: READ_KICK_SCHED_TIMEOUT_EN.
module read_kick_sched
    import read_kick_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned RING_WORDS = 65536,
    parameter int unsigned MAX_CHUNK  = 1024,
    parameter int unsigned MIN_CHUNK  = 64,
    localparam int unsigned PW        = $clog2(RING_WORDS) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          flush,
    input  logic [PW-1:0] wr_ptr,
    output logic          kick,
    output logic [31:0]   read_addr,
    output logic [31:0]   read_num,
    input  logic          busy,
    output logic [PW-1:0] rd_ptr,
    output logic          active
`ifdef READ_KICK_SCHED_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    state_e        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   read_addr_q, read_addr_d;
    logic [31:0]   read_num_q, read_num_d;
    logic [PW-1:0] avail;
    logic [PW-1:0] chunk;
    logic          start_ok;

    ring_avail_calc #(
        .RING_WORDS (RING_WORDS),
        .MAX_CHUNK  (MAX_CHUNK),
        .PW         (PW)
    ) u_avail (
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr_q),
        .avail  (avail),
        .chunk  (chunk)
    );

    assign start_ok = enable && ((avail >= PW'(MIN_CHUNK)) || (flush && (avail != '0)));

`ifdef READ_KICK_SCHED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        read_addr_d = read_addr_q;
        read_num_d  = read_num_q;
`ifdef READ_KICK_SCHED_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = CALC;
            end
            CALC: begin
                read_num_d  = 32'(chunk);
                read_addr_d = BASE_ADDR + 32'(rd_ptr_q[PW-2:0]) * 32'(WORD_BYTES);
                state_d     = KICK;
            end
            KICK: begin
                state_d = WAIT_BUSY;
`ifdef READ_KICK_SCHED_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_d = WAIT_DONE;
                end
`ifdef READ_KICK_SCHED_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Give up on the chunk; rd_ptr stays put so it is retried.
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
            WAIT_DONE: begin
                if (!busy) begin
                    rd_ptr_d = rd_ptr_q + read_num_q[PW-1:0];
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            read_addr_q <= BASE_ADDR;
            read_num_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            read_addr_q <= read_addr_d;
            read_num_q  <= read_num_d;
        end
    end

`ifdef READ_KICK_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign kick      = (state_q == KICK);
    assign active    = (state_q != IDLE);
    assign read_addr = read_addr_q;
    assign read_num  = read_num_q;
    assign rd_ptr    = rd_ptr_q;

endmodule
